// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - two-requester round-robin APB master for the PSEL1/PSEL2 slave pair
module apb_master_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int SEL_BIT = 6,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,

  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_done,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_err,

  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_done,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_err,

  output logic              cs,
  output logic              PSEL1,
  output logic              PSEL2,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              slverr
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_DONE,
    S_ERR
  } state_t;

  state_t              state;
  logic                last_grant;
  logic                cur;
  logic [CNT_W-1:0]    tmo_cnt;
  logic [CNT_W-1:0]    tmo_next;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;

  logic                grant_any;
  logic                grant_id;
  logic                g_write;
  logic [ADDR_W-1:0]   g_addr;
  logic [DATA_W-1:0]   g_wdata;
  logic                dec_err;

  // Both pending: serve whoever was not granted last; otherwise the lone requester.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_id  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    g_write   = grant_id ? req1_write : req0_write;
    g_addr    = grant_id ? req1_addr  : req0_addr;
    g_wdata   = grant_id ? req1_wdata : req0_wdata;
    dec_err   = |(g_addr >> (SEL_BIT + 1));
  end

  assign tmo_next = (tmo_cnt == CNT_W'(TIMEOUT)) ? tmo_cnt : tmo_cnt + 1'b1;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      cur        <= 1'b0;
      tmo_cnt    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      req0_ready <= 1'b0;
      req0_done  <= 1'b0;
      req0_rdata <= '0;
      req0_err   <= 1'b0;
      req1_ready <= 1'b0;
      req1_done  <= 1'b0;
      req1_rdata <= '0;
      req1_err   <= 1'b0;
      cs         <= 1'b0;
      PSEL1      <= 1'b0;
      PSEL2      <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
    end else begin
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      req0_done  <= 1'b0;
      req1_done  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (grant_any) begin
            last_grant <= grant_id;
            cur        <= grant_id;
            tmo_cnt    <= '0;
            if (grant_id) req1_ready <= 1'b1;
            else          req0_ready <= 1'b1;
            if (dec_err) begin
              state <= S_ERR;
            end else begin
              state  <= S_SETUP;
              cs     <= 1'b1;
              PSEL1  <= ~g_addr[SEL_BIT];
              PSEL2  <= g_addr[SEL_BIT];
              PWRITE <= g_write;
              PADDR  <= {{(ADDR_W - SEL_BIT){1'b0}}, g_addr[SEL_BIT-1:0]};
              PWDATA <= g_wdata;
            end
          end
        end

        S_SETUP: begin
          PENABLE <= 1'b1;
          state   <= S_ACCESS;
        end

        S_ACCESS: begin
          if (PREADY) begin
            rdata_q <= (PWRITE || slverr) ? '0 : PRDATA;
            err_q   <= slverr;
            cs      <= 1'b0;
            PSEL1   <= 1'b0;
            PSEL2   <= 1'b0;
            PENABLE <= 1'b0;
            state   <= S_DONE;
          end else begin
            tmo_cnt <= tmo_next;
            // Abort once the slave has stalled for TIMEOUT access cycles.
            if (tmo_next == CNT_W'(TIMEOUT)) begin
              cs      <= 1'b0;
              PSEL1   <= 1'b0;
              PSEL2   <= 1'b0;
              PENABLE <= 1'b0;
              state   <= S_ERR;
            end
          end
        end

        S_DONE: begin
          if (cur) begin
            req1_done  <= 1'b1;
            req1_rdata <= rdata_q;
            req1_err   <= err_q;
          end else begin
            req0_done  <= 1'b1;
            req0_rdata <= rdata_q;
            req0_err   <= err_q;
          end
          state <= S_IDLE;
        end

        S_ERR: begin
          if (cur) begin
            req1_done  <= 1'b1;
            req1_rdata <= '0;
            req1_err   <= 1'b1;
          end else begin
            req0_done  <= 1'b1;
            req0_rdata <= '0;
            req0_err   <= 1'b1;
          end
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - randomized self-checking bench for apb_master_arbiter
module tb_apb_master_arbiter;

  logic        PCLK, PRESETn;
  logic        req0_valid, req0_write, req0_ready, req0_done, req0_err;
  logic [63:0] req0_addr, req0_wdata, req0_rdata;
  logic        req1_valid, req1_write, req1_ready, req1_done, req1_err;
  logic [63:0] req1_addr, req1_wdata, req1_rdata;
  logic        cs, PSEL1, PSEL2, PENABLE, PWRITE, PREADY, slverr;
  logic [63:0] PADDR, PWDATA, PRDATA;

  apb_master_arbiter #(.ADDR_W(64), .DATA_W(64), .SEL_BIT(6), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_done(req0_done),
    .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_done(req1_done),
    .req1_rdata(req1_rdata), .req1_err(req1_err),
    .cs(cs), .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .slverr(slverr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] model_mem [0:127];
  logic [63:0] slave_mem [0:127];
  int          model_last;
  int          cfg_waits;
  logic        cfg_err;
  logic        stuck;

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int who, input logic v, input logic wr,
                         input logic [63:0] addr, input logic [63:0] wdata);
    if (who == 0) begin
      req0_valid = v; req0_write = wr; req0_addr = addr; req0_wdata = wdata;
    end else begin
      req1_valid = v; req1_write = wr; req1_addr = addr; req1_wdata = wdata;
    end
  endtask

  // Two 64-entry register slaves with programmable wait states, indexed by select + PADDR.
  initial begin
    int wcnt;
    int idx;
    PREADY = 1'b0; PRDATA = '0; slverr = 1'b0; wcnt = 0;
    for (int i = 0; i < 128; i++) slave_mem[i] = '0;
    forever begin
      @(posedge PCLK); #1;
      if (cs && PENABLE && !stuck) begin
        if (wcnt >= cfg_waits) begin
          idx    = (PSEL2 ? 64 : 0) + int'(PADDR[5:0]);
          PREADY = 1'b1;
          slverr = cfg_err;
          if (PWRITE) begin
            PRDATA = '0;
            if (!cfg_err) slave_mem[idx] = PWDATA;
          end else begin
            PRDATA = slave_mem[idx];
          end
        end else begin
          PREADY = 1'b0;
          wcnt++;
        end
      end else begin
        PREADY = 1'b0;
        slverr = 1'b0;
        wcnt   = 0;
      end
    end
  end

  task automatic run_one(input int who, input logic wr, input logic [63:0] addr,
                         input logic [63:0] wdata, input int waits, input logic serr,
                         input logic stk);
    logic        decerr, exp_err, got_ready, got_done, other_done, bus_seen;
    logic [63:0] exp_rd;
    int          exp_lat, n, pen, cyc;
    decerr  = (addr >> 7) != 0;
    exp_err = decerr || stk || serr;
    exp_rd  = (wr || exp_err) ? 64'd0 : model_mem[addr[6:0]];
    exp_lat = decerr ? 1 : (stk ? 18 : 3 + waits);
    cfg_waits = waits; cfg_err = serr; stuck = stk;

    set_req(who, 1'b1, wr, addr, wdata);
    cyc = 0; got_ready = 1'b0;
    while (!got_ready && cyc < 20) begin
      @(posedge PCLK); #1; cyc++;
      got_ready = (who == 0) ? req0_ready : req1_ready;
    end
    set_req(who, 1'b0, 1'b0, '0, '0);
    if (!got_ready) begin
      check_eq("ready_timeout", 64'd0, 64'd1);
      return;
    end
    model_last = who;

    if (decerr) begin
      check_eq("decerr_no_bus", {61'd0, cs, PSEL1, PSEL2}, 64'd0);
    end else begin
      check_eq("setup_phase", {62'd0, cs, PENABLE}, 64'b10);
      check_eq("setup_psel", {62'd0, PSEL2, PSEL1}, addr[6] ? 64'b10 : 64'b01);
      check_eq("setup_paddr", PADDR, {58'd0, addr[5:0]});
      check_eq("setup_pwrite", {63'd0, PWRITE}, {63'd0, wr});
      check_eq("setup_pwdata", PWDATA, wdata);
    end

    n = 0; pen = 0; got_done = 1'b0; other_done = 1'b0; bus_seen = 1'b0;
    while (!got_done && n < 40) begin
      @(posedge PCLK); #1; n++;
      if (PENABLE) pen++;
      if (cs || PSEL1 || PSEL2) bus_seen = 1'b1;
      got_done   = (who == 0) ? req0_done : req1_done;
      other_done = other_done | ((who == 0) ? req1_done : req0_done);
    end
    if (!got_done) begin
      check_eq("done_timeout", 64'd0, 64'd1);
      return;
    end
    check_eq("latency", 64'(n), 64'(exp_lat));
    check_eq("done_err", {63'd0, (who == 0) ? req0_err : req1_err}, {63'd0, exp_err});
    check_eq("done_rdata", (who == 0) ? req0_rdata : req1_rdata, exp_rd);
    check_eq("other_done", {63'd0, other_done}, 64'd0);
    check_eq("bus_released", {61'd0, cs, PSEL1, PSEL2}, 64'd0);
    if (decerr) check_eq("decerr_bus_quiet", {63'd0, bus_seen}, 64'd0);
    if (stk) check_eq("timeout_access_cycles", 64'(pen), 64'd16);
    if (wr && !exp_err) model_mem[addr[6:0]] = wdata;
    stuck = 1'b0;
  endtask

  // Both requesters held valid; grants must alternate from the round-robin rule.
  task automatic run_arb(input logic [63:0] a0, input logic [63:0] a1);
    int   cyc, who, exp_who;
    logic r0, r1, d;
    cfg_waits = 0; cfg_err = 1'b0; stuck = 1'b0;
    set_req(0, 1'b1, 1'b0, a0, '0);
    set_req(1, 1'b1, 1'b0, a1, '0);
    for (int g = 0; g < 4; g++) begin
      exp_who = 1 - model_last;
      cyc = 0; r0 = 1'b0; r1 = 1'b0;
      while (!(r0 || r1) && cyc < 20) begin
        @(posedge PCLK); #1; cyc++;
        r0 = req0_ready; r1 = req1_ready;
      end
      if (g == 3) begin
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
      end
      if (!(r0 || r1)) begin
        check_eq("arb_ready_timeout", 64'd0, 64'd1);
        return;
      end
      check_eq("arb_one_grant", {62'd0, r1, r0}, (exp_who == 1) ? 64'b10 : 64'b01);
      who = r1 ? 1 : 0;
      model_last = who;
      cyc = 0; d = 1'b0;
      while (!d && cyc < 20) begin
        @(posedge PCLK); #1; cyc++;
        if (cs && (req0_ready || req1_ready)) check_eq("arb_overlap", 64'd1, 64'd0);
        d = (who == 0) ? req0_done : req1_done;
      end
      check_eq("arb_done", {63'd0, d}, 64'd1);
      check_eq("arb_rdata", (who == 0) ? req0_rdata : req1_rdata,
               model_mem[(who == 0) ? a0[6:0] : a1[6:0]]);
    end
  endtask

  initial begin
    int          who, r, waits;
    logic        wr, serr, seen_done;
    logic [63:0] addr, wdata;

    for (int i = 0; i < 128; i++) model_mem[i] = '0;
    model_last = 1;
    cfg_waits = 0; cfg_err = 1'b0; stuck = 1'b0;
    PRESETn = 1'b0;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge PCLK);
    #1;
    check_eq("reset_ctrl", {54'd0, cs, PSEL1, PSEL2, PENABLE, PWRITE, req0_ready, req0_done,
                            req0_err, req1_ready, req1_done}, 64'd0);
    check_eq("reset_bus", PADDR | PWDATA | req0_rdata | req1_rdata | {63'd0, req1_err}, 64'd0);
    PRESETn = 1'b1;

    run_one(0, 1'b1, 64'h45, 64'hDEAD, 0, 1'b0, 1'b0);
    run_one(1, 1'b0, 64'h45, '0, 0, 1'b0, 1'b0);
    run_one(0, 1'b1, 64'h05, 64'h1234_5678_9ABC_DEF0, 2, 1'b0, 1'b0);
    run_one(1, 1'b0, 64'h05, '0, 1, 1'b0, 1'b0);
    run_arb(64'h05, 64'h45);
    run_one(0, 1'b0, 64'h80, '0, 0, 1'b0, 1'b0);
    run_one(1, 1'b1, 64'h1_0000_0000_0003, 64'h77, 0, 1'b0, 1'b0);
    run_one(0, 1'b0, 64'h45, '0, 0, 1'b1, 1'b0);
    run_one(1, 1'b0, 64'h12, '0, 0, 1'b0, 1'b1);

    // Reset asserted in the middle of an ACCESS phase.
    stuck = 1'b1;
    set_req(0, 1'b1, 1'b0, 64'h10, '0);
    @(posedge PCLK); #1;
    set_req(0, 1'b0, 1'b0, '0, '0);
    check_eq("rst_pre_ready", {63'd0, req0_ready}, 64'd1);
    repeat (3) @(posedge PCLK);
    #1;
    check_eq("rst_pre_access", {63'd0, PENABLE}, 64'd1);
    #2 PRESETn = 1'b0;
    #1;
    check_eq("rst_async_ctrl", {58'd0, cs, PSEL1, PSEL2, PENABLE, req0_ready, req0_done}, 64'd0);
    check_eq("rst_async_bus", PADDR | PWDATA, 64'd0);
    seen_done = 1'b0;
    repeat (2) begin
      @(posedge PCLK); #1;
      seen_done = seen_done | req0_done | req1_done;
    end
    PRESETn = 1'b1;
    stuck = 1'b0;
    model_last = 1;
    repeat (3) begin
      @(posedge PCLK); #1;
      seen_done = seen_done | req0_done | req1_done | cs;
    end
    check_eq("rst_no_done", {63'd0, seen_done}, 64'd0);
    run_arb(64'h45, 64'h05);

    for (int k = 0; k < 40; k++) begin
      who   = int'($urandom_range(0, 1));
      wr    = 1'($urandom_range(0, 1));
      r     = int'($urandom_range(0, 9));
      addr  = (r == 0) ? (64'h80 | 64'($urandom_range(0, 127)))
                       : 64'($urandom_range(0, 127));
      wdata = {$urandom, $urandom};
      waits = int'($urandom_range(0, 3));
      serr  = ($urandom_range(0, 7) == 0);
      run_one(who, wr, addr, wdata, waits, serr, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
